// File: rtl/deflate_pipe_pkg.sv
// Shared Deflate pipeline types: skid buffer state encoding and statistics width.
package deflate_pipe_pkg;

  typedef enum logic [1:0] {SB_EMPTY, SB_BUSY, SB_FULL} sb_state_t;

  localparam int STAT_W = 32;

endpackage

// File: rtl/skid_buffer_en_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module sat_counter
  import deflate_pipe_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/skid_buffer_en.sv
// Two-entry elastic stage with registered in_ready and downstream load enable.
// Optional statistics counters are built when SKID_BUFFER_STATS_EN is defined.
module skid_buffer_en
  import deflate_pipe_pkg::*;
#(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              load_en
`ifdef SKID_BUFFER_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] xfer_cnt
`endif
);

  sb_state_t  state_q, state_d;
  logic [N-1:0] m_q, s_q;
  logic in_fire, out_fire;
  logic m_load, m_from_s, s_load;

  assign out_valid = (state_q != SB_EMPTY);
  assign out_data  = m_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign load_en   = out_fire;

  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    case (state_q)
      SB_EMPTY: begin
        if (in_fire) begin
          state_d = SB_BUSY;
          m_load  = 1'b1;
        end
      end
      SB_BUSY: begin
        if (in_fire && out_fire) begin
          m_load = 1'b1;
        end else if (in_fire) begin
          state_d = SB_FULL;
          s_load  = 1'b1;
        end else if (out_fire) begin
          state_d = SB_EMPTY;
        end
      end
      SB_FULL: begin
        if (out_fire) begin
          state_d  = SB_BUSY;
          m_load   = 1'b1;
          m_from_s = 1'b1;
        end
      end
      default: state_d = SB_EMPTY;
    endcase
  end

  // in_ready is registered from next_state so back-pressure never depends on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SB_EMPTY;
      m_q      <= '0;
      s_q      <= '0;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != SB_FULL);
      if (m_load) begin
        m_q <= m_from_s ? s_q : in_data;
      end
      if (s_load) begin
        s_q <= in_data;
      end
    end
  end

`ifdef SKID_BUFFER_STATS_EN
  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(STAT_W)) u_xfer_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_fire),
    .count (xfer_cnt)
  );
`endif

endmodule

// File: tb/tb_skid_buffer_en.sv
// Directed-vector bench for skid_buffer_en; stats checks built with SKID_BUFFER_STATS_EN.
module tb_skid_buffer_en;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        load_en;
`ifdef SKID_BUFFER_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] xfer_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned le_count;

  always #5 clk = ~clk;

  skid_buffer_en #(.N(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .load_en   (load_en)
`ifdef SKID_BUFFER_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are applied 1ns after the rising edge, outputs checked 1ns later.
  task automatic cyc(input string tag, input logic iv, input logic [31:0] id, input logic ordy,
                     input logic eov, input logic [31:0] eod, input logic eir, input logic ele);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(eov));
    check({tag, ".in_ready"},  64'(in_ready),  64'(eir));
    check({tag, ".load_en"},   64'(load_en),   64'(ele));
    if (eov) check({tag, ".out_data"}, 64'(out_data), 64'(eod));
    if (load_en) le_count++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b1;
    // Reset held two cycles while offering 0xAA
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst.out_data", 64'(out_data), 64'h0);
    cyc("rst0", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc("rst1", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc("rst2", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming 0x01..0x10, word k presented one cycle after its in_fire
    le_count = 0;
    for (int k = 0; k <= 16; k++) begin
      cyc($sformatf("strm%0d", k), (k < 16), 32'(k + 1), 1'b1,
          (k > 0), 32'(k), 1'b1, (k > 0));
    end
    cyc("strm_end", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check("strm.load_en_cycles", 64'(le_count), 64'd16);

    // Single-cycle stall while 0x01 is presented
    cyc("ss0", 1'b1, 32'h01, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
    cyc("ss1", 1'b1, 32'h02, 1'b0, 1'b1, 32'h01, 1'b1, 1'b0);
    cyc("ss2", 1'b1, 32'h03, 1'b1, 1'b1, 32'h01, 1'b0, 1'b1);
    cyc("ss3", 1'b1, 32'h03, 1'b1, 1'b1, 32'h02, 1'b1, 1'b1);
    cyc("ss4", 1'b0, 32'h00, 1'b1, 1'b1, 32'h03, 1'b1, 1'b1);
    cyc("ss5", 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);

    // Long stall: 10 cycles of out_ready low with in_valid held
    cyc("ls0", 1'b1, 32'h11, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
    cyc("ls1", 1'b1, 32'h12, 1'b0, 1'b1, 32'h11, 1'b1, 1'b0);
    for (int k = 2; k < 10; k++) begin
      cyc($sformatf("ls%0d", k), 1'b1, 32'h13, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
    end
    cyc("ls10", 1'b1, 32'h13, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1);
    cyc("ls11", 1'b0, 32'h00, 1'b1, 1'b1, 32'h12, 1'b1, 1'b1);
    cyc("ls12", 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);

    // Reset while FULL with 0x55/0x66 flushes both words
    cyc("rf0", 1'b1, 32'h55, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
    cyc("rf1", 1'b1, 32'h66, 1'b0, 1'b1, 32'h55, 1'b1, 1'b0);
    reset = 1'b1;
    cyc("rf2", 1'b0, 32'h00, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
    reset = 1'b0;
    check("rf.out_data_cleared", 64'(out_data), 64'h0);
    for (int k = 3; k < 6; k++) begin
      cyc($sformatf("rf%0d", k), 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
    end

`ifdef SKID_BUFFER_STATS_EN
    do_reset();
    check("stat.rst_stall", 64'(stall_cnt), 64'd0);
    check("stat.rst_xfer",  64'(xfer_cnt),  64'd0);
    cyc("st0", 1'b1, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cyc($sformatf("st_stall%0d", k), 1'b0, 32'h00, 1'b0, 1'b1, 32'h01, 1'b1, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc($sformatf("st_xfer%0d", k), 1'b1, 32'(k + 2), 1'b1, 1'b1, 32'(k + 1), 1'b1, 1'b1);
    end
    cyc("st_last", 1'b0, 32'h00, 1'b1, 1'b1, 32'h05, 1'b1, 1'b1);
    check("stat.xfer_cnt",  64'(xfer_cnt),  64'd5);
    check("stat.stall_cnt", 64'(stall_cnt), 64'd7);
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count;
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    check("stat.stall_sat", 64'(stall_cnt), 64'hFFFF_FFFF);
`else
    do_reset();
    check("post_reset.in_ready", 64'(in_ready), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skid_buffer_en.md
# skid_buffer_en

Two-entry elastic pipeline stage with valid/ready handshaking on both sides. It sits directly upstream of the enable-gated register chains in the Deflate datapath. It converts a downstream stall (`out_ready` low) into a registered upstream back-pressure (`in_ready`) without dropping or duplicating data. It also exports `load_en`, the per-cycle enable that the downstream enabled registers consume.

## Interface
- `N`, default 32: data width in bits.
- `clk`  in  1: clock; all logic on rising edge.
- `reset`  in  1: reset, synchronous, active-high; clock `clk`.
- `in_data`  in  N: upstream data.
- `in_valid`  in  1: upstream data valid.
- `in_ready`  out  1: stage can accept; registered.
- `out_data`  out  N: data presented downstream; registered.
- `out_valid`  out  1: `out_data` valid; registered.
- `out_ready`  in  1: downstream accepts this cycle.
- `load_en`  out  1: `out_valid & out_ready`; combinational enable for downstream registers.
- `stall_cnt`  out  32: present only with `SKID_BUFFER_STATS_EN`.
- `xfer_cnt`  out  32: present only with `SKID_BUFFER_STATS_EN`.

## Operation
- Storage:
  - main register `M` drives `out_data`.
  - skid register `S` holds one overflow word.
- Fires:
  - `in_fire = in_valid & in_ready`.
  - `out_fire = out_valid & out_ready`.
- State machine states: EMPTY (`M`, `S` invalid), BUSY (`M` valid), FULL (`M`, `S` valid).
- EMPTY:
  - `in_fire` -> BUSY, `M <= in_data`.
  - Otherwise stay.
- BUSY:
  - `in_fire & out_fire` -> BUSY, `M <= in_data`.
  - `in_fire & !out_fire` -> FULL, `S <= in_data`.
  - `!in_fire & out_fire` -> EMPTY.
  - Neither -> stay.
- FULL:
  - `in_ready = 0`, so `in_fire` is impossible.
  - `out_fire` -> BUSY, `M <= S`.
  - Otherwise stay, holding `M` and `S` unchanged.
- Output decode:
  - `out_valid = (state != EMPTY)`.
  - `in_ready = (next_state != FULL)`, registered.
- Ordering: strict FIFO. No word is lost or duplicated under any `in_valid`/`out_ready` pattern.
- `out_data` holds its value whenever `out_valid & !out_ready`, and is stable for the whole stall.
- `in_data` is ignored when `in_valid = 0`.
- `in_valid` may drop without a handshake; the block does not require the AXI-style "no retract" rule.

## Timing
- Reset values:
  - state = EMPTY
  - `out_valid = 0`, `out_data = 0`
  - `in_ready = 1`
  - `S = 0`
  - counters = 0
- Inputs during an asserted-`reset` cycle are discarded, even if `in_valid & in_ready`.
- Reset mid-operation flushes both entries in the next cycle with no drain.
- Latency: `in_fire` on cycle t gives `out_valid` with that word on cycle t+1, provided the buffer is EMPTY or draining.
- Throughput: one word per cycle sustained while `out_ready = 1`.
- Stall response: `out_ready` low on cycle t while BUSY with `in_fire` -> FULL at t+1 and `in_ready = 0` at t+1. The accepted word sits in `S`.
- Recovery: from FULL, `out_ready` high on cycle t -> `in_ready = 1` at t+1.
- `load_en` has zero latency: it is asserted in the same cycle as `out_fire`.

## Configuration
- Macro: `SKID_BUFFER_STATS_EN`.
- With the macro defined:
  - `stall_cnt` increments on every cycle with `out_valid & !out_ready`.
  - `xfer_cnt` increments on every `out_fire`.
  - Both counters saturate at `32'hFFFF_FFFF` and clear on `reset`.
- Without the macro: both ports and all counter logic are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package `deflate_pipe_pkg` holds:
  - `typedef enum logic [1:0] {SB_EMPTY, SB_BUSY, SB_FULL} sb_state_t`
  - `localparam int STAT_W = 32`
- One natural sub-module, `sat_counter` (width `STAT_W`, inputs `inc` and `reset`). It is instantiated twice under `SKID_BUFFER_STATS_EN`.
- The datapath (`M`, `S`, mux) stays in the top module.

## Test plan
- **Reset:** hold `reset` 2 cycles with `in_valid = 1`, `in_data = 0xAA` -> after release `out_valid = 0`, `out_data = 0`, `in_ready = 1`, and no 0xAA emitted.
- **Streaming:** stream 0x01..0x10 with `out_ready = 1` -> `out_data` 0x01..0x10 on consecutive cycles, first word one cycle after its `in_fire`, `load_en` high 16 cycles.
- **Single-cycle stall:** send 0x01, 0x02, 0x03 back-to-back, with `out_ready = 0` for one cycle while 0x01 is presented -> `in_ready` drops for exactly one cycle, `out_data` holds 0x01, and output order is 0x01, 0x02, 0x03 with no loss.
- **Long stall:** `out_ready = 0` for 10 cycles with `in_valid` held high -> exactly 2 words accepted, `in_ready = 0` from cycle 2. On release, the two words drain in order and `in_ready = 1` the cycle after the first drain.
- **Reset mid-FULL:** reach FULL holding 0x55, 0x66, then pulse `reset` -> next cycle `out_valid = 0` and neither word is ever emitted.
- **Stats (`SKID_BUFFER_STATS_EN`):** 5 transfers plus 7 stall cycles -> `xfer_cnt = 5`, `stall_cnt = 7`. With `stall_cnt` forced near `0xFFFFFFFE`, 3 more stall cycles leave it at `0xFFFFFFFF`.
